// File: rtl/irrigation_zone_scheduler_if.sv
// Bundles the scheduler's sensor, timing-program and valve/pump signals.
// The slave side is the scheduler; the master side is whatever feeds the
// sensor samples and programmed times and consumes the valve/pump drives.
interface irrigation_zone_scheduler_if #(
    parameter int NZONES = 4,
    parameter int SW     = 7,
    parameter int TW     = 7
);
    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;

    logic                   enable;
    logic [NZONES*SW-1:0]   m_sense;
    logic [SW-1:0]          m_thresh;
    logic [TW-1:0]          water_time;
    logic [TW-1:0]          rest_time;
    logic [NZONES-1:0]      valve;
    logic                   pump;
    logic [ZW-1:0]          active_zone;
    logic                   zone_done;
    logic [1:0]             state;

    modport master (
        output enable, m_sense, m_thresh, water_time, rest_time,
        input  valve, pump, active_zone, zone_done, state
    );

    modport slave (
        input  enable, m_sense, m_thresh, water_time, rest_time,
        output valve, pump, active_zone, zone_done, state
    );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation scheduler: one zone at a time shares the pump
// manifold. A grant waters for water_time ticks, then the pump rests for
// rest_time ticks before the scheduler may grant again. The FSM state is
// exported on bus.state so checkers can follow IDLE/WATER/REST directly.
module irrigation_zone_scheduler #(
    parameter int NZONES = 4,
    parameter int SW     = 7,
    parameter int TW     = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    irrigation_zone_scheduler_if.slave   bus
);
    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WATER = 2'd1;
    localparam logic [1:0] S_REST  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [ZW-1:0]     rr_q, rr_d;
    logic [NZONES-1:0] valve_q, valve_d;
    logic              pump_q, pump_d;
    logic [ZW-1:0]     zone_q, zone_d;
    logic              done_q, done_d;

    logic [NZONES-1:0] req;
    logic              any_req;
    logic [ZW-1:0]     winner;
    logic [TW-1:0]     water_last;
    logic [TW-1:0]     rest_last;
    logic              water_end;
    logic              rest_end;
    logic              grant;

    // A zone asks for water whenever its sample is at or below the threshold.
    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            req[i] = (bus.m_sense[i*SW +: SW] <= bus.m_thresh);
        end
    end

    // First requesting zone at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = '0;
        for (int k = 0; k < NZONES; k++) begin
            idx = (int'(rr_q) + k) % NZONES;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = ZW'(idx);
            end
        end
    end

    // Programmed times are sampled live; a zero time behaves as one tick.
    always_comb begin
        water_last = (bus.water_time == '0) ? '0 : bus.water_time - TW'(1);
        rest_last  = (bus.rest_time  == '0) ? '0 : bus.rest_time  - TW'(1);
        water_end  = (cnt_q == water_last);
        rest_end   = (cnt_q == rest_last);
        grant      = (state_q == S_IDLE) && bus.enable && any_req;
    end

    // State and interval counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; an enable drop aborts watering ahead of completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_WATER;
                    cnt_d   = '0;
                end
            end
            S_WATER: begin
                if (!bus.enable || water_end) begin
                    state_d = S_REST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_REST: begin
                if (rest_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered drives, grant bookkeeping and done pulse.
    always_comb begin
        valve_d = valve_q;
        pump_d  = pump_q;
        zone_d  = zone_q;
        rr_d    = rr_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    valve_d         = '0;
                    valve_d[winner] = 1'b1;
                    pump_d          = 1'b1;
                    zone_d          = winner;
                    rr_d            = (winner == ZW'(NZONES - 1)) ? '0 : winner + ZW'(1);
                end
            end
            S_WATER: begin
                if (!bus.enable || water_end) begin
                    valve_d = '0;
                    pump_d  = 1'b0;
                    done_d  = bus.enable;
                end
            end
            S_REST: begin
                valve_d = '0;
                pump_d  = 1'b0;
            end
            default: begin
                valve_d = '0;
                pump_d  = 1'b0;
                zone_d  = '0;
            end
        endcase
    end

    // Output and round-robin pointer register; reset clears the drives at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            valve_q <= '0;
            pump_q  <= 1'b0;
            zone_q  <= '0;
            done_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            valve_q <= valve_d;
            pump_q  <= pump_d;
            zone_q  <= zone_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.valve       = valve_q;
    assign bus.pump        = pump_q;
    assign bus.active_zone = zone_q;
    assign bus.zone_done   = done_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: a cycle-by-cycle vector table for the
// basic reset / single-zone timing, then hand sequences for round-robin order,
// pointer wrap, abort, zero times and mid-watering reset.
module tb_irrigation_zone_scheduler;
    localparam int NZONES = 4;
    localparam int SW     = 7;
    localparam int TW     = 7;
    localparam int ZW     = 2;

    localparam logic [SW-1:0] DRY = 7'd30;
    localparam logic [SW-1:0] WET = 7'd80;
    localparam logic [SW-1:0] THR = 7'd50;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_on   = 1'b0;

    // Clock: 10 ns period, active edge at posedge.
    always #5 clk = ~clk;

    irrigation_zone_scheduler_if #(.NZONES(NZONES), .SW(SW), .TW(TW)) bus ();

    irrigation_zone_scheduler #(.NZONES(NZONES), .SW(SW), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic                 rst;
        logic                 en;
        logic [NZONES*SW-1:0] ms;
        logic [TW-1:0]        wt;
        logic [TW-1:0]        rt;
        logic [NZONES-1:0]    exp_valve;
        logic [1:0]           exp_state;
        logic [ZW-1:0]        exp_zone;
        logic                 exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [NZONES*SW-1:0] ms4(input logic [SW-1:0] z0, z1, z2, z3);
        return {z3, z2, z1, z0};
    endfunction

    function automatic void add(input logic r, input logic en, input logic [NZONES*SW-1:0] ms,
                                input logic [TW-1:0] wt, input logic [TW-1:0] rt,
                                input logic [NZONES-1:0] ev, input logic [1:0] es,
                                input logic [ZW-1:0] ez, input logic ed);
        vec_t v;
        v.rst = r; v.en = en; v.ms = ms; v.wt = wt; v.rt = rt;
        v.exp_valve = ev; v.exp_state = es; v.exp_zone = ez; v.exp_done = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string nm, input logic [NZONES-1:0] ev, input logic [1:0] es,
                              input logic [ZW-1:0] ez, input logic ed);
        chk({nm, "_valve"}, 32'(bus.valve), 32'(ev));
        chk({nm, "_pump"},  32'(bus.pump),  32'(|ev));
        chk({nm, "_state"}, 32'(bus.state), 32'(es));
        chk({nm, "_zone"},  32'(bus.active_zone), 32'(ez));
        chk({nm, "_done"},  32'(bus.zone_done), 32'(ed));
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs({nm, "_reset"}, '0, 2'd0, '0, 1'b0);
    endtask

    // Ticks until a valve opens; n is the number of edges it took.
    task automatic wait_grant(input string nm, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.valve == '0 && n < 200);
        if (bus.valve == '0) begin
            checks++;
            failures++;
            $display("FAIL %s_grant_timeout: actual=no_grant required=grant", nm);
        end
    endtask

    // Follows one grant from the grant sample through WATER and REST into IDLE.
    task automatic check_grant(input string nm, input int zone, input int exp_len,
                               input int exp_rest, input logic exp_done);
        int len;
        int rest;
        logic [NZONES-1:0] oh;
        oh = '0;
        oh[zone] = 1'b1;
        check_outs({nm, "_grant"}, oh, 2'd1, ZW'(zone), 1'b0);
        len = 1;
        while (len < 300) begin
            tick();
            if (bus.valve == '0) break;
            chk({nm, "_valve_hold"}, 32'(bus.valve), 32'(oh));
            len++;
        end
        chk({nm, "_water_len"}, 32'(len), 32'(exp_len));
        chk({nm, "_done_pulse"}, 32'(bus.zone_done), 32'(exp_done));
        chk({nm, "_rest_entry"}, 32'(bus.state), 32'd2);
        rest = 1;
        while (rest < 300) begin
            tick();
            if (bus.state != 2'd2) break;
            chk({nm, "_done_low"}, 32'(bus.zone_done), 32'd0);
            rest++;
        end
        chk({nm, "_rest_len"}, 32'(rest), 32'(exp_rest));
        chk({nm, "_idle"}, 32'(bus.state), 32'd0);
    endtask

    // Invariants that hold every cycle once out of the first reset.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("mon_pump_or", 32'(bus.pump), 32'(|bus.valve));
            chk("mon_onehot0", 32'($onehot0(bus.valve)), 32'd1);
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NZONES*SW-1:0] all_wet;
        logic [NZONES*SW-1:0] z2;
        int n;
        int order[5];
        int rest;

        rst = 1'b1;
        bus.enable     = 1'b0;
        bus.m_thresh   = THR;
        bus.m_sense    = '0;
        bus.water_time = '0;
        bus.rest_time  = '0;

        all_wet = ms4(WET, WET, WET, WET);
        z2      = ms4(WET, WET, DRY, WET);

        // Reset, then 20 idle cycles with every zone wet.
        add(1'b1, 1'b1, all_wet, 7'd5, 7'd3, 4'b0000, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++)
            add(1'b0, 1'b1, all_wet, 7'd5, 7'd3, 4'b0000, 2'd0, 2'd0, 1'b0);
        // Zone 2 dry: 5 cycles of water, done pulse, 3 rest cycles, 1 idle, regrant.
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, z2, 7'd5, 7'd3, 4'b0100, 2'd1, 2'd2, 1'b0);
        add(1'b0, 1'b1, z2, 7'd5, 7'd3, 4'b0000, 2'd2, 2'd2, 1'b1);
        add(1'b0, 1'b1, z2, 7'd5, 7'd3, 4'b0000, 2'd2, 2'd2, 1'b0);
        add(1'b0, 1'b1, z2, 7'd5, 7'd3, 4'b0000, 2'd2, 2'd2, 1'b0);
        add(1'b0, 1'b1, z2, 7'd5, 7'd3, 4'b0000, 2'd0, 2'd2, 1'b0);
        add(1'b0, 1'b1, z2, 7'd5, 7'd3, 4'b0100, 2'd1, 2'd2, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            bus.enable     = vecs[i].en;
            bus.m_sense    = vecs[i].ms;
            bus.water_time = vecs[i].wt;
            bus.rest_time  = vecs[i].rt;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_valve, vecs[i].exp_state,
                       vecs[i].exp_zone, vecs[i].exp_done);
            mon_on = 1'b1;
        end

        // Round robin with every zone dry: 0,1,2,3,0 with a one-cycle idle gap.
        bus.m_sense    = ms4(DRY, DRY, DRY, DRY);
        bus.water_time = 7'd2;
        bus.rest_time  = 7'd1;
        bus.enable     = 1'b1;
        do_reset("rr");
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("rr%0d", k), n);
            chk($sformatf("rr%0d_gap", k), 32'(n), 32'd1);
            check_grant($sformatf("rr%0d", k), order[k], 2, 1, 1'b1);
        end

        // Pointer at 2 with zones 1 and 3 dry: zone 3 first, then zone 1.
        bus.m_sense = ms4(WET, DRY, WET, WET);
        do_reset("ptr");
        wait_grant("ptr_a", n);
        bus.m_sense = ms4(WET, DRY, WET, DRY);
        check_grant("ptr_a", 1, 2, 1, 1'b1);
        wait_grant("ptr_b", n);
        check_grant("ptr_b", 3, 2, 1, 1'b1);
        wait_grant("ptr_c", n);
        check_grant("ptr_c", 1, 2, 1, 1'b1);

        // Abort: enable drops in the third watering cycle of a 10-cycle grant.
        bus.m_sense    = ms4(DRY, WET, WET, WET);
        bus.water_time = 7'd10;
        bus.rest_time  = 7'd4;
        do_reset("abort");
        wait_grant("abort", n);
        chk("abort_first_edge", 32'(n), 32'd1);
        tick();
        tick();
        chk("abort_cycle3_valve", 32'(bus.valve), 32'd1);
        bus.enable = 1'b0;
        tick();
        check_outs("abort_edge", 4'b0000, 2'd2, 2'd0, 1'b0);
        rest = 1;
        while (rest < 300) begin
            tick();
            if (bus.state != 2'd2) break;
            chk("abort_done_low", 32'(bus.zone_done), 32'd0);
            rest++;
        end
        chk("abort_rest_len", 32'(rest), 32'd4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs($sformatf("abort_hold%0d", k), 4'b0000, 2'd0, 2'd0, 1'b0);
        end

        // Abort on the edge that would otherwise complete a one-cycle grant.
        bus.enable     = 1'b1;
        bus.water_time = 7'd1;
        wait_grant("abort1", n);
        bus.enable = 1'b0;
        tick();
        check_outs("abort1_edge", 4'b0000, 2'd2, 2'd0, 1'b0);

        // Zero times behave as one; then reset while the valve is open.
        bus.m_sense    = ms4(WET, DRY, WET, WET);
        bus.water_time = 7'd0;
        bus.rest_time  = 7'd0;
        bus.enable     = 1'b1;
        do_reset("zero");
        wait_grant("zero_a", n);
        chk("zero_a_latency", 32'(n), 32'd1);
        check_grant("zero_a", 1, 1, 1, 1'b1);
        wait_grant("zero_b", n);
        chk("zero_b_gap", 32'(n), 32'd1);
        check_outs("zero_b_grant", 4'b0010, 2'd1, 2'd1, 1'b0);
        rst = 1'b1;
        tick();
        check_outs("mid_reset", 4'b0000, 2'd0, 2'd0, 1'b0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irrigation_zone_scheduler.md
# irrigation_zone_scheduler

Multi-zone watering scheduler that shares the single pump/valve manifold between `NZONES` moisture-sensed zones. It runs on the 1 Hz `clk` from the clock divider, samples per-zone moisture against one shared threshold, and grants at most one zone at a time. Grants are round-robin. Each grant waters for a programmed time, then a mandatory pump rest period follows before the next grant. It sits between the ADC sensor outputs and the valve/pump drivers, and replaces the per-zone single-valve controllers.

## Interface
Parameters:
- `NZONES`, 4, number of zones (2..8)
- `SW`, 7, moisture sample / threshold width
- `TW`, 7, timer width for water and rest times

Ports:
- `clk`  in  1  1 Hz tick from clock divider; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  watering window open (e.g. dawn); level
- `m_sense`  in  NZONES*SW  packed moisture samples, zone i at bits [i*SW +: SW]
- `m_thresh`  in  SW  shared dryness threshold
- `water_time`  in  TW  watering duration per grant, in clk cycles
- `rest_time`  in  TW  pump rest after each grant, in clk cycles
- `valve`  out  NZONES  one-hot valve drive; all zero when not watering
- `pump`  out  1  pump drive; 1 exactly when a valve bit is 1
- `active_zone`  out  $clog2(NZONES)  index of last/current granted zone
- `zone_done`  out  1  one-cycle pulse when a grant completes its full water_time
- `state`  out  2  IDLE=0, WATER=1, REST=2

## Operation
- Request: `req[i] = (m_sense[i] <= m_thresh)`, unsigned, combinational, re-evaluated every cycle.
- Round-robin pointer `rr_ptr`: the winner is the first i with `req[i]` found scanning from `rr_ptr` upward, wrapping at NZONES-1 → 0.
- IDLE:
  - If `enable` and any `req`: on the edge, state←WATER, valve←onehot(winner), pump←1, active_zone←winner, rr_ptr←(winner+1) mod NZONES, cnt←0.
  - Otherwise hold.
- WATER:
  - Each edge, cnt←cnt+1.
  - When cnt == max(water_time,1)−1: valve←0, pump←0, zone_done←1 for one cycle, state←REST, cnt←0.
  - If `enable`=0 at any edge in WATER: abort. valve←0, pump←0, state←REST, cnt←0, no zone_done. Abort takes priority over normal completion on the same edge.
  - Moisture changes during WATER are ignored; the grant runs to completion or abort.
- REST:
  - Each edge, cnt←cnt+1.
  - When cnt == max(rest_time,1)−1: state←IDLE, cnt←0.
  - REST always completes, regardless of `enable`.
- `water_time` and `rest_time` are sampled live. Changing them mid-interval affects the current comparison.
- Effective range is 1..2^TW−1. A value of 0 behaves as 1.
- Unreachable state encoding 3 → IDLE on the next edge with all outputs cleared.

## Timing
- Reset values: state=IDLE, valve=0, pump=0, active_zone=0, zone_done=0, rr_ptr=0, cnt=0.
- Reset asserted mid-WATER clears valve/pump on that same edge.
- All outputs are registered.
- Grant latency: `valve` rises on the first edge where IDLE ∧ enable ∧ any req.
- Watering duration: `valve` stays high for exactly max(water_time,1) cycles when not aborted.
- Gap: at least max(rest_time,1) cycles from `valve` falling to IDLE, plus one cycle in IDLE before the next grant. Minimum valve-low gap = max(rest_time,1)+1 cycles.
- `zone_done` is high during the first REST cycle only.
- `pump` == |`valve` in every cycle; never two valve bits high.

## Test plan
- Reset, m_thresh=50, all m_sense=80, enable=1 for 20 cycles → state stays 0, valve=0, pump=0.
- NZONES=4, zone 2 m_sense=30, others 80, water_time=5, rest_time=3, enable=1 → valve=4'b0100 for 5 cycles, zone_done pulse, REST 3 cycles, IDLE 1 cycle, then regrant zone 2.
- All zones dry, water_time=2, rest_time=1 → grant order 0,1,2,3,0.
- Zones 1 and 3 dry, rr_ptr=2 → zone 3 granted first, then zone 1.
- Zone 0 watering, enable dropped at cycle 3 of water_time=10 → valve=0 next edge, no zone_done, REST runs full rest_time.
- water_time=0, rest_time=0, zone 1 dry → valve high 1 cycle, REST 1 cycle, IDLE 1 cycle, repeat. `rst` pulsed while valve high → valve, pump, state all 0 on that edge.
